// File: rtl/audio_codec_pkg.sv
// Shared constants and state encoding for the codec audio interface blocks.
package audio_codec_pkg;

    localparam int DATA_W_DEF      = 16;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2
    } rx_state_t;

endpackage

// File: rtl/i2s_adc_rx_if.sv
// Stereo sample bus with valid/ready handshake between capture and consumer.
interface i2s_adc_rx_if
    import audio_codec_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic [DATA_W-1:0] sample_l;
    logic [DATA_W-1:0] sample_r;
    logic              sample_valid;
    logic              sample_ready;

    modport master (output sample_l, output sample_r, output sample_valid, input sample_ready);
    modport slave  (input sample_l, input sample_r, input sample_valid, output sample_ready);
endinterface

// File: rtl/i2s_adc_rx_sync.sv
// Multi-stage synchroniser for a pin clock and its companion pins, with rise
// detect on the clock; companions share the same depth so they stay aligned.
module pin_sync_edge #(
    parameter int STAGES = 2,
    parameter int W      = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clk_pin,
    input  logic [W-1:0] i_pins,
    output logic         o_rise,
    output logic [W-1:0] o_pins
);
    logic [STAGES-1:0][W:0] r_stage;
    logic                   r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= '0;
            r_prev  <= 1'b0;
        end else begin
            r_stage[0] <= {i_pins, i_clk_pin};
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
            r_prev <= r_stage[STAGES-1][0];
        end
    end

    assign o_rise = r_stage[STAGES-1][0] & ~r_prev;
    assign o_pins = r_stage[STAGES-1][W:1];
endmodule

// File: rtl/i2s_adc_rx.sv
// I2S ADC capture: deserialises MSB-first left/right words on bclk rises and
// presents completed stereo pairs on a held valid/ready register.
module i2s_adc_rx
    import audio_codec_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic         clk,
    input  logic         RESET_n,
    input  logic         enable,
    input  logic         aud_bclk,
    input  logic         aud_lrclk,
    input  logic         aud_adcdat,
    i2s_adc_rx_if.master smp,
    output logic         overrun,
    output logic         frame_err,
    input  logic         clear_err,
    output logic         locked
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic              w_rise;
    logic [1:0]        w_pins;
    logic              w_lr, w_dat, w_trans, w_full, w_last, w_in_slot;
    logic              w_cap, w_short, w_pair, w_load, w_ovr;
    logic [DATA_W-1:0] w_word;

    rx_state_t         r_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-2:0] r_shift;
    logic [DATA_W-1:0] r_left_hold;
    logic              r_left_got;
    logic              r_lr_prev;
    logic [DATA_W-1:0] r_sample_l, r_sample_r;
    logic              r_valid, r_overrun, r_frame_err;

    pin_sync_edge #(.STAGES(SYNC_STAGES), .W(2)) u_sync (
        .clk       (clk),
        .rst_n     (RESET_n),
        .i_clk_pin (aud_bclk),
        .i_pins    ({aud_adcdat, aud_lrclk}),
        .o_rise    (w_rise),
        .o_pins    (w_pins)
    );

    assign w_lr      = w_pins[0];
    assign w_dat     = w_pins[1];
    assign w_trans   = w_lr != r_lr_prev;
    assign w_full    = r_bit_cnt == CNT_W'(DATA_W);
    assign w_last    = r_bit_cnt == CNT_W'(DATA_W - 1);
    assign w_word    = {r_shift, w_dat};
    assign w_in_slot = (r_state == LEFT) || (r_state == RIGHT);

    // Right-channel LSB completes the pair combinationally so the output loads on this edge.
    assign w_cap   = enable & w_rise & w_in_slot & ~w_trans & ~w_full;
    assign w_short = enable & w_rise & w_in_slot & w_trans & ~w_full;
    assign w_pair  = w_cap & (r_state == RIGHT) & w_last & r_left_got;
    assign w_load  = w_pair & (~r_valid | smp.sample_ready);
    assign w_ovr   = w_pair & ~w_load;

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            r_lr_prev <= 1'b0;
        end else if (w_rise) begin
            r_lr_prev <= w_lr;
        end
    end

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state     <= SEARCH;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_left_hold <= '0;
            r_left_got  <= 1'b0;
        end else if (!enable) begin
            r_state    <= SEARCH;
            r_bit_cnt  <= '0;
            r_left_got <= 1'b0;
        end else if (w_rise) begin
            case (r_state)
                SEARCH: begin
                    if (!w_lr && r_lr_prev) begin
                        r_state    <= LEFT;
                        r_bit_cnt  <= '0;
                        r_left_got <= 1'b0;
                    end
                end
                LEFT, RIGHT: begin
                    if (w_trans) begin
                        r_state   <= w_lr ? RIGHT : LEFT;
                        r_bit_cnt <= '0;
                        if (!w_lr) begin
                            r_left_got <= 1'b0;
                        end
                    end else if (!w_full) begin
                        r_shift   <= w_word[DATA_W-2:0];
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (w_last && r_state == LEFT) begin
                            r_left_hold <= w_word;
                            r_left_got  <= 1'b1;
                        end
                    end
                end
                default: r_state <= SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            r_sample_l  <= '0;
            r_sample_r  <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_load) begin
                r_sample_l <= r_left_hold;
                r_sample_r <= w_word;
                r_valid    <= 1'b1;
            end else if (r_valid && smp.sample_ready) begin
                r_valid <= 1'b0;
            end
            r_overrun   <= (r_overrun & ~clear_err) | w_ovr;
            r_frame_err <= (r_frame_err & ~clear_err) | w_short;
        end
    end

    assign smp.sample_l     = r_sample_l;
    assign smp.sample_r     = r_sample_r;
    assign smp.sample_valid = r_valid;
    assign overrun          = r_overrun;
    assign frame_err        = r_frame_err;
    assign locked           = r_state != SEARCH;
endmodule
